// File: rtl/mlp_epoch_sequencer_pkg.sv
// Shared types for the MLP epoch sequencer.
// sfp/HALF mirror the FixedPoint Q8.8 signed format used by the MLP core.
package mlp_epoch_sequencer_pkg;

    typedef logic signed [15:0] sfp;

    localparam sfp HALF = 16'sh0080;

    typedef enum logic [2:0] {
        IDLE,
        TRAIN,
        EVAL,
        TEST,
        DONE
    } seq_state_t;

endpackage

// File: rtl/mlp_epoch_sequencer_match_check.sv
// Combinational class-match check across all MLP outputs.
// An example matches when every output lands on the same side of threshold.
module mlp_match_check
    import mlp_epoch_sequencer_pkg::*;
#(
    parameter int OUTPUTS = 1
) (
    input  sfp   [OUTPUTS-1:0] prediction,
    input  sfp   [OUTPUTS-1:0] expected,
    input  sfp                 threshold,
    output logic               match
);

    // Equal-to-threshold counts as "not below" on both sides.
    always_comb begin
        match = 1'b1;
        for (int o = 0; o < OUTPUTS; o++) begin
            if (($signed(prediction[o]) < $signed(threshold)) !=
                ($signed(expected[o]) < $signed(threshold))) begin
                match = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mlp_epoch_sequencer.sv
// Training/evaluation sequencer: epochs of TRAIN, then a scored TEST pass.
// Optional MLP_SEQ_EARLY_STOP_EN adds a per-epoch EVAL pass with early stop.
module mlp_epoch_sequencer
    import mlp_epoch_sequencer_pkg::*;
#(
    parameter  int OUTPUTS   = 1,
    parameter  int NUM_TRAIN = 70,
    parameter  int NUM_TEST  = 30,
    parameter  int EPOCHS    = 100,
    parameter  int HOLD      = 1,
    parameter  int IDX_W     = $clog2(NUM_TRAIN + NUM_TEST),
    localparam int EP_W      = $clog2(EPOCHS + 1),
    localparam int TC_W      = $clog2(NUM_TEST + 1),
    localparam int HC_W      = (HOLD > 1) ? $clog2(HOLD) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  sfp                    threshold,
    input  sfp    [OUTPUTS-1:0]   expected,
    input  sfp    [OUTPUTS-1:0]   prediction,
    output logic  [IDX_W-1:0]     example,
    output logic                  training,
    output logic                  busy,
    output logic  [EP_W-1:0]      epoch,
    output logic  [TC_W-1:0]      test_correct,
    output logic                  done,
    output logic                  early_stop
);

    localparam logic [IDX_W-1:0] LAST_TRAIN = IDX_W'(NUM_TRAIN - 1);
    localparam logic [IDX_W-1:0] FIRST_TEST = IDX_W'(NUM_TRAIN);
    localparam logic [IDX_W-1:0] LAST_TEST  = IDX_W'(NUM_TRAIN + NUM_TEST - 1);
    localparam logic [HC_W-1:0]  HOLD_LAST  = HC_W'(HOLD - 1);
    localparam logic [EP_W-1:0]  EP_MAX     = EP_W'(EPOCHS);
    localparam logic [TC_W-1:0]  TC_MAX     = TC_W'(NUM_TEST);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic [EP_W-1:0]  epoch_q, epoch_d;
    logic [TC_W-1:0]  tc_q, tc_d;
    sfp               thr_q, thr_d;
    logic             training_q, training_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             match;
    logic             hold_last;
    logic [EP_W-1:0]  ep_inc;
`ifdef MLP_SEQ_EARLY_STOP_EN
    logic             es_q, es_d;
    logic             eval_ok_q, eval_ok_d;
    logic             ok_now;
`endif

    mlp_match_check #(
        .OUTPUTS    (OUTPUTS)
    ) u_match (
        .prediction (prediction),
        .expected   (expected),
        .threshold  (thr_q),
        .match      (match)
    );

    assign hold_last = (hold_q == HOLD_LAST);
    assign ep_inc    = (epoch_q == EP_MAX) ? epoch_q : epoch_q + 1'b1;

    // Next-state and next-output logic for the run sequencer.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        epoch_d    = epoch_q;
        tc_d       = tc_q;
        thr_d      = thr_q;
        training_d = training_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef MLP_SEQ_EARLY_STOP_EN
        es_d       = es_q;
        eval_ok_d  = eval_ok_q;
        ok_now     = eval_ok_q & match;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    thr_d      = threshold;
                    epoch_d    = '0;
                    tc_d       = '0;
`ifdef MLP_SEQ_EARLY_STOP_EN
                    es_d       = 1'b0;
`endif
                    state_d    = TRAIN;
                    idx_d      = '0;
                    hold_d     = '0;
                    training_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            TRAIN: begin
                if (!hold_last) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    hold_d = '0;
                    if (idx_q == LAST_TRAIN) begin
                        epoch_d = ep_inc;
                        idx_d   = '0;
`ifdef MLP_SEQ_EARLY_STOP_EN
                        state_d    = EVAL;
                        training_d = 1'b0;
                        eval_ok_d  = 1'b1;
`else
                        if (ep_inc == EP_MAX) begin
                            state_d    = TEST;
                            idx_d      = FIRST_TEST;
                            training_d = 1'b0;
                        end
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef MLP_SEQ_EARLY_STOP_EN
            EVAL: begin
                if (!hold_last) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    hold_d    = '0;
                    eval_ok_d = ok_now;
                    if (idx_q == LAST_TRAIN) begin
                        if (ok_now) begin
                            state_d = TEST;
                            idx_d   = FIRST_TEST;
                            es_d    = 1'b1;
                        end else if (epoch_q < EP_MAX) begin
                            state_d    = TRAIN;
                            idx_d      = '0;
                            training_d = 1'b1;
                        end else begin
                            state_d = TEST;
                            idx_d   = FIRST_TEST;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`endif
            TEST: begin
                if (!hold_last) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    hold_d = '0;
                    if (match && (tc_q != TC_MAX)) begin
                        tc_d = tc_q + 1'b1;
                    end
                    if (idx_q == LAST_TEST) begin
                        state_d = DONE;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                idx_d      = '0;
                hold_d     = '0;
                training_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and registered outputs; async reset returns everything to idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            hold_q     <= '0;
            epoch_q    <= '0;
            tc_q       <= '0;
            thr_q      <= '0;
            training_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MLP_SEQ_EARLY_STOP_EN
            es_q       <= 1'b0;
            eval_ok_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            epoch_q    <= epoch_d;
            tc_q       <= tc_d;
            thr_q      <= thr_d;
            training_q <= training_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef MLP_SEQ_EARLY_STOP_EN
            es_q       <= es_d;
            eval_ok_q  <= eval_ok_d;
`endif
        end
    end

    assign example      = idx_q;
    assign training     = training_q;
    assign busy         = busy_q;
    assign epoch        = epoch_q;
    assign test_correct = tc_q;
    assign done         = done_q;
`ifdef MLP_SEQ_EARLY_STOP_EN
    assign early_stop   = es_q;
`else
    assign early_stop   = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_epoch_sequencer.sv
// Scoreboard bench for mlp_epoch_sequencer (default build, early stop off).
// 3 outputs, 4 train rows, 3 test rows, 2 epochs, hold 2.
module tb_mlp_epoch_sequencer;
    import mlp_epoch_sequencer_pkg::*;

    localparam int OUT = 3;
    localparam int NT  = 4;
    localparam int NTS = 3;
    localparam int EP  = 2;
    localparam int HD  = 2;

    localparam sfp ONE = 16'sh0100;

    typedef struct packed {
        logic [2:0] ex;
        logic       tr;
        logic       bs;
        logic       dn;
        logic [1:0] ep;
        logic [1:0] tc;
        logic       es;
    } rec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    sfp             threshold = '0;
    sfp   [OUT-1:0] expected;
    sfp   [OUT-1:0] prediction;
    logic [2:0]     example;
    logic           training;
    logic           busy;
    logic [1:0]     epoch;
    logic [1:0]     test_correct;
    logic           done;
    logic           early_stop;

    sfp   [OUT-1:0] exp_tbl [8];
    sfp   [OUT-1:0] pred_tbl [8];
    sfp   [OUT-1:0] bad_v;
    logic [2:0]     prev_ex = '0;

    rec_t q[$];
    rec_t act_r;
    rec_t exp_r;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mlp_epoch_sequencer #(
        .OUTPUTS      (OUT),
        .NUM_TRAIN    (NT),
        .NUM_TEST     (NTS),
        .EPOCHS       (EP),
        .HOLD         (HD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .threshold    (threshold),
        .expected     (expected),
        .prediction   (prediction),
        .example      (example),
        .training     (training),
        .busy         (busy),
        .epoch        (epoch),
        .test_correct (test_correct),
        .done         (done),
        .early_stop   (early_stop)
    );

    // Data ROM and MLP stand-in: first cycle of each index gives a bad guess.
    always @(posedge clk) prev_ex <= example;
    always @* begin
        expected   = exp_tbl[example];
        prediction = (example != prev_ex) ? bad_v : pred_tbl[example];
    end

    function automatic void chk(input string name,
                                input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // Monitor: every busy or done cycle must match the next queued record.
    always @(negedge clk) begin
        if (rst && (busy || done)) begin
            act_r = {example, training, busy, done,
                     epoch, test_correct, early_stop};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cycle actual=%h required=none",
                         act_r);
            end else begin
                exp_r = q.pop_front();
                if (act_r !== exp_r) begin
                    errors++;
                    $display("FAIL cycle_rec t=%0t actual ex=%0d tr=%0d bs=%0d dn=%0d ep=%0d tc=%0d es=%0d required ex=%0d tr=%0d bs=%0d dn=%0d ep=%0d tc=%0d es=%0d",
                             $time, act_r.ex, act_r.tr, act_r.bs, act_r.dn,
                             act_r.ep, act_r.tc, act_r.es,
                             exp_r.ex, exp_r.tr, exp_r.bs, exp_r.dn,
                             exp_r.ep, exp_r.tc, exp_r.es);
                end
            end
        end
    end

    // Queue the full cycle-by-cycle response of one run; m = per-row match.
    task automatic push_run(input logic [NTS-1:0] m);
        rec_t r;
        int   cnt = 0;
        for (int e = 0; e < EP; e++) begin
            for (int i = 0; i < NT; i++) begin
                for (int h = 0; h < HD; h++) begin
                    r = '{ex: 3'(i), tr: 1'b1, bs: 1'b1, dn: 1'b0,
                          ep: 2'(e), tc: 2'd0, es: 1'b0};
                    q.push_back(r);
                end
            end
        end
        for (int t = 0; t < NTS; t++) begin
            for (int h = 0; h < HD; h++) begin
                r = '{ex: 3'(NT + t), tr: 1'b0, bs: 1'b1, dn: 1'b0,
                      ep: 2'(EP), tc: 2'(cnt), es: 1'b0};
                q.push_back(r);
            end
            if (m[t]) cnt++;
        end
        r = '{ex: 3'd0, tr: 1'b0, bs: 1'b0, dn: 1'b1,
              ep: 2'(EP), tc: 2'(cnt), es: 1'b0};
        q.push_back(r);
    endtask

    task automatic run_start(input sfp thr);
        @(negedge clk);
        threshold = thr;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        threshold = 16'sh7fff;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_example"}, {29'd0, example}, 32'd0);
        chk({tag, "_training"}, {31'd0, training}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_epoch"}, {30'd0, epoch}, 32'd0);
        chk({tag, "_tc"}, {30'd0, test_correct}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_es"}, {31'd0, early_stop}, 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) begin
            exp_tbl[i]  = '0;
            pred_tbl[i] = '0;
        end
        bad_v = {3{16'sh7000}};
        // Row 4: 0.7/0.9/0.2 vs 1/1/0 -> match at HALF and at 1.5.
        exp_tbl[4]  = {16'sh0000, ONE, ONE};
        pred_tbl[4] = {16'sh0033, 16'sh00E6, 16'sh00B3};
        // Row 5: output 1 = 0.6 vs 0 crosses HALF wrongly.
        exp_tbl[5]  = {ONE, 16'sh0000, ONE};
        pred_tbl[5] = {16'sh00E6, 16'sh009A, 16'sh00B3};
        // Row 6: output 0 exactly HALF vs 1; output 2 = -0.5 vs 0.
        exp_tbl[6]  = {16'sh0000, ONE, ONE};
        pred_tbl[6] = {16'shFF80, ONE, HALF};

        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Run 1: threshold HALF, rows 4 and 6 match.
        push_run(3'b101);
        run_start(HALF);
        wait_done();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
        chk("tc_hold", {30'd0, test_correct}, 32'd2);
        chk("epoch_hold", {30'd0, epoch}, 32'd2);
        repeat (2) @(negedge clk);
        chk("still_idle", {31'd0, busy}, 32'd0);
        chk("tc_still", {30'd0, test_correct}, 32'd2);

        // Run 2: threshold 1.5, every row matches; start clears counters.
        push_run(3'b111);
        run_start(16'sh0180);
        wait_done();
        @(negedge clk);
        chk("tc_sat", {30'd0, test_correct}, 32'd3);

        // Run 3: reset in the middle of epoch 1, with a stray start first.
        push_run(3'b101);
        run_start(HALF);
        n = 0;
        while (epoch != 2'd1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("epoch1_reached", {30'd0, epoch}, 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("busy_mid_train", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        q.delete();
        #1;
        chk_idle("midrst");
        @(negedge clk);
        #2;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("queue_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mlp_epoch_sequencer.md
Name: mlp_epoch_sequencer

Overview:
Synthesizable training/evaluation sequencer for the MLP core; replaces the hand-written epoch loop in simulation benches.
- Drives the dataset example index and the MLP `training` strobe over a configurable number of epochs.
- Then runs a held-out test pass and scores classification accuracy across all outputs against a threshold.
- Sits between the Data ROM (example index in; values/expected out) and the MLP (training in; prediction out).

Parameters:
OUTPUTS, 1, number of MLP outputs compared per example
NUM_TRAIN, 70, training examples, dataset indices 0..NUM_TRAIN-1
NUM_TEST, 30, test examples, indices NUM_TRAIN..NUM_TRAIN+NUM_TEST-1
EPOCHS, 100, maximum training epochs (>=1)
HOLD, 1, cycles each example index is held (>=1; covers MLP prediction latency)
IDX_W, $clog2(NUM_TRAIN+NUM_TEST), example index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  1-cycle request to begin a run; ignored unless idle
threshold  in  sfp  class boundary; sampled on accepted start
expected  in  sfp[OUTPUTS]  from Data
prediction  in  sfp[OUTPUTS]  from MLP
example  out  IDX_W  dataset index
training  out  1  MLP learning enable
busy  out  1  high from first TRAIN cycle through last TEST cycle
epoch  out  $clog2(EPOCHS+1)  completed training epochs
test_correct  out  $clog2(NUM_TEST+1)  correct test examples, valid when done
done  out  1  1-cycle pulse at end of run
early_stop  out  1  run ended before EPOCHS; held until next start

Behaviour:
- Reset (rst low, any time, including mid-run):
  - FSM goes to IDLE.
  - example, training, busy, epoch, test_correct, done, early_stop all 0.
  - Sampled threshold cleared to 0.
- FSM states: IDLE, TRAIN, EVAL (only with the optional feature), TEST, DONE.
- IDLE:
  - On start=1: latch threshold; clear epoch, test_correct and early_stop.
  - Next cycle enter TRAIN with example=0 and training=1.
- TRAIN:
  - Each index is held HOLD cycles, then increments.
  - After index NUM_TRAIN-1 completes its hold, epoch increments.
  - If epoch reaches EPOCHS, go to TEST; otherwise restart TRAIN at index 0.
  - training stays 1 continuously across epoch boundaries.
- TEST:
  - training=0; example runs from NUM_TRAIN to NUM_TRAIN+NUM_TEST-1, each held HOLD cycles.
  - On the last hold cycle of each example, evaluate match. Match = for every output o, (prediction[o] < thr) == (expected[o] < thr), using signed sfp compare.
  - test_correct increments on match (registered).
- DONE:
  - Lasts one cycle: done=1, busy=0, example=0; then IDLE.
  - test_correct and epoch hold their values until the next accepted start.
- Timing (no optional feature): cycle S = start sampled.
  - TRAIN covers S+1 .. S+EPOCHS*NUM_TRAIN*HOLD.
  - TEST covers the next NUM_TEST*HOLD cycles.
  - done asserts in the cycle after that.
- Boundaries:
  - start while busy or in DONE is ignored.
  - Equality to threshold counts as "not below".
  - Counters never wrap: epoch saturates at EPOCHS, test_correct at NUM_TEST.

Optional Feature:
MLP_SEQ_EARLY_STOP_EN.
- Defined:
  - After each training epoch, enter EVAL: training=0, indices 0..NUM_TRAIN-1, same hold/match rule.
  - If all NUM_TRAIN examples match, go directly to TEST and set early_stop=1.
  - Otherwise, if epoch < EPOCHS return to TRAIN; else go to TEST with early_stop=0.
- Undefined: no EVAL state exists; early_stop is tied to 0.

Decomposition:
- Common package:
  - seq_state_t enum (IDLE, TRAIN, EVAL, TEST, DONE).
  - Reuse sfp and HALF from FixedPoint; no new fixed-point types.
- Sub-module mlp_match_check (combinational): parameter OUTPUTS; inputs prediction, expected, threshold; output match.
  - Shared by the TEST and EVAL paths; also reusable by benches.

Test Plan:
- Cycle count: OUTPUTS=1, NUM_TRAIN=4, NUM_TEST=2, EPOCHS=2, HOLD=1, start at cycle S.
  - Response: training=1 with example 0,1,2,3,0,1,2,3 over S+1..S+8.
  - Then training=0 with example 4,5 over S+9..S+10.
  - done=1 at S+11; epoch=2.
- Scoring: HOLD=2, threshold=HALF, predictions 0.7/0.2 against expected 1.0/1.0 on the test rows.
  - Response: test_correct=1.
  - Each index held 2 cycles; compare uses the second cycle only.
- Multi-output: OUTPUTS=3, one output crosses the threshold wrongly on one test example.
  - Response: that example is not counted.
  - Prediction exactly equal to threshold with expected 1.0 counts as a match.
- Reset and re-start:
  - Deassert rst mid-TRAIN, epoch=1 → all outputs 0 next edge; busy=0.
  - start pulse during busy is ignored.
  - New start after done clears test_correct.
- Early stop (MLP_SEQ_EARLY_STOP_EN): EPOCHS=10, predictions forced to always match.
  - Response: EVAL follows epoch 1 with training=0, then TEST.
  - done with epoch=1 and early_stop=1.
